// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: widths, opcodes, fetch state encoding, bubble value.
// S_HALT exists only when FETCH_HALT_EN is defined.
package pipe_pkg;

  localparam int PIPE_ADDR_W  = 5;
  localparam int PIPE_INSTR_W = 20;

  localparam logic [3:0] OP_ADD     = 4'b0000;
  localparam logic [3:0] OP_HALT    = 4'b1100;
  localparam logic [3:0] OP_COPY_IN = 4'b1111;

  // All-zero word decodes as a no-op downstream.
  localparam logic [PIPE_INSTR_W-1:0] BUBBLE = '0;

`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} fetch_state_t;
`else
  typedef enum logic [1:0] {S_BOOT, S_RUN} fetch_state_t;
`endif

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter: load has priority over increment, otherwise hold; wraps modulo 2^ADDR_W.
module pc_reg #(
  parameter int ADDR_W   = 5,
  parameter int RESET_PC = 0
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pc <= ADDR_W'(RESET_PC);
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: drives memory address from PC, registers the read word into IF/ID.
// Optional halt-on-opcode behaviour is enabled by defining FETCH_HALT_EN.
module fetch_stage
  import pipe_pkg::*;
#(
  parameter int ADDR_W   = PIPE_ADDR_W,
  parameter int INSTR_W  = PIPE_INSTR_W,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 8
) (
  input  logic               Clock,
  input  logic               Resetn,
  output logic [ADDR_W-1:0]  addr,
  input  logic [INSTR_W-1:0] q,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic               ifid_valid,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  fetch_state_t state, nxt_state;
  logic pc_load, pc_inc, capture, bubble;

  pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc_reg (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (redirect_pc),
    .pc       (addr)
  );

  always_comb begin
    nxt_state = state;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    capture   = 1'b0;
    bubble    = 1'b0;
    case (state)
      S_BOOT: begin
        pc_load   = redirect;
        nxt_state = S_RUN;
      end
      S_RUN: begin
        if (redirect) begin
          pc_load = 1'b1;
          bubble  = 1'b1;
        end else if (!stall) begin
          capture = 1'b1;
`ifdef FETCH_HALT_EN
          // PC parks on the halt word so a later redirect is the only way out.
          if (q[INSTR_W-1 -: 4] == OP_HALT) nxt_state = S_HALT;
          else                              pc_inc    = 1'b1;
`else
          pc_inc  = 1'b1;
`endif
        end
      end
`ifdef FETCH_HALT_EN
      S_HALT: begin
        bubble = 1'b1;
        if (redirect) begin
          pc_load   = 1'b1;
          nxt_state = S_RUN;
        end
      end
`endif
      default: nxt_state = S_RUN;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state       <= S_BOOT;
      ifid_instr  <= '0;
      ifid_pc     <= '0;
      ifid_valid  <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= nxt_state;
      if (capture) begin
        ifid_instr <= q;
        ifid_pc    <= addr;
        ifid_valid <= 1'b1;
        if (fetch_count != '1) fetch_count <= fetch_count + CNT_W'(1);
      end else if (bubble) begin
        ifid_instr <= INSTR_W'(BUBBLE);
        ifid_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_HALT_EN
  assign halted = (state == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded bench for fetch_stage: captures are queued by stimulus and checked by a monitor.
module tb_fetch_stage;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic [4:0]  addr;
  logic [19:0] q;
  logic        stall, redirect;
  logic [4:0]  redirect_pc;
  logic [19:0] ifid_instr;
  logic [4:0]  ifid_pc;
  logic        ifid_valid, halted;
  logic [7:0]  fetch_count;

  logic [19:0] mem [32];
  assign q = mem[addr];

  typedef struct packed {
    logic [4:0]  pc;
    logic [19:0] instr;
  } exp_t;
  exp_t exp_q[$];

  int  tests = 0;
  int  fails = 0;
  logic adv_q = 1'b0;

  fetch_stage dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .addr        (addr),
    .q           (q),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ifid_instr  (ifid_instr),
    .ifid_pc     (ifid_pc),
    .ifid_valid  (ifid_valid),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: a valid IF/ID word following an un-stalled, un-redirected edge is a new capture.
  always @(posedge Clock) adv_q = Resetn && !stall && !redirect;

  always @(negedge Clock) begin
    if (Resetn && adv_q && ifid_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_capture actual_pc=%0h required=none at %0t", ifid_pc, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_ifid_pc", 32'(ifid_pc), 32'(e.pc));
        chk("sb_ifid_instr", 32'(ifid_instr), 32'(e.instr));
      end
    end
  end

  task automatic tick(input logic s, input logic r, input logic [4:0] rpc);
    stall = s;
    redirect = r;
    redirect_pc = rpc;
    @(posedge Clock);
    @(negedge Clock);
    #1;
  endtask

  task automatic adv_expect(input logic [4:0] pc);
    exp_t e;
    e.pc = pc;
    e.instr = mem[pc];
    exp_q.push_back(e);
    tick(1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 20'h01000 + 20'(i);
    mem[0]  = 20'hF0001;
    mem[1]  = 20'hF0002;
    mem[2]  = 20'hF0003;
    mem[3]  = 20'hC0000;
    mem[7]  = 20'h07007;
    mem[31] = 20'h0A01F;

    Resetn = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 5'd0;
    @(negedge Clock);
    #1;
    chk("rst_valid", 32'(ifid_valid), 32'd0);
    chk("rst_instr", 32'(ifid_instr), 32'd0);
    chk("rst_pc", 32'(ifid_pc), 32'd0);
    chk("rst_count", 32'(fetch_count), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    Resetn = 1'b1;

    tick(1'b0, 1'b0, 5'd0);
    chk("boot_valid", 32'(ifid_valid), 32'd0);
    chk("boot_addr", 32'(addr), 32'd0);
    adv_expect(5'd0);
    adv_expect(5'd1);
    adv_expect(5'd2);
    chk("run_count", 32'(fetch_count), 32'd3);
    chk("run_addr", 32'(addr), 32'd3);

    tick(1'b0, 1'b1, 5'd0);
    chk("redir0_valid", 32'(ifid_valid), 32'd0);
    chk("redir0_instr", 32'(ifid_instr), 32'd0);
    chk("redir0_addr", 32'(addr), 32'd0);
    chk("redir0_count", 32'(fetch_count), 32'd3);
    adv_expect(5'd0);
    adv_expect(5'd1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 5'd0);
      chk("stall_pc", 32'(ifid_pc), 32'd1);
      chk("stall_instr", 32'(ifid_instr), 32'hF0002);
      chk("stall_valid", 32'(ifid_valid), 32'd1);
      chk("stall_addr", 32'(addr), 32'd2);
      chk("stall_count", 32'(fetch_count), 32'd5);
    end
    adv_expect(5'd2);
    adv_expect(5'd3);
    chk("halt_word_count", 32'(fetch_count), 32'd7);

`ifdef FETCH_HALT_EN
    tick(1'b0, 1'b0, 5'd0);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_bubble", 32'(ifid_valid), 32'd0);
    chk("halt_addr", 32'(addr), 32'd3);
    tick(1'b1, 1'b0, 5'd0);
    chk("halt_flag2", 32'(halted), 32'd1);
    chk("halt_bubble2", 32'(ifid_valid), 32'd0);
    chk("halt_addr2", 32'(addr), 32'd3);
    tick(1'b0, 1'b1, 5'd0);
    chk("unhalt_flag", 32'(halted), 32'd0);
    chk("unhalt_valid", 32'(ifid_valid), 32'd0);
    chk("unhalt_addr", 32'(addr), 32'd0);
    adv_expect(5'd0);
    chk("resume_addr", 32'(addr), 32'd1);
`else
    adv_expect(5'd4);
    chk("nohalt_flag", 32'(halted), 32'd0);
    chk("nohalt_addr", 32'(addr), 32'd5);
`endif
    chk("mid_count", 32'(fetch_count), 32'd8);

    tick(1'b1, 1'b1, 5'd7);
    chk("redir7_valid", 32'(ifid_valid), 32'd0);
    chk("redir7_addr", 32'(addr), 32'd7);
    chk("redir7_count", 32'(fetch_count), 32'd8);
    adv_expect(5'd7);
    chk("after7_addr", 32'(addr), 32'd8);

    tick(1'b0, 1'b1, 5'd31);
    chk("redir31_addr", 32'(addr), 32'd31);
    adv_expect(5'd31);
    adv_expect(5'd0);
    chk("wrap_addr", 32'(addr), 32'd1);
    chk("wrap_count", 32'(fetch_count), 32'd11);

    tick(1'b0, 1'b1, 5'd4);
    adv_expect(5'd4);
    adv_expect(5'd5);
    chk("pre_rst_pc", 32'(ifid_pc), 32'd5);
    chk("pre_rst_count", 32'(fetch_count), 32'd13);

    // Async reset between edges: outputs must clear with no clock edge.
    stall = 1'b0;
    redirect = 1'b0;
    Resetn = 1'b0;
    #1;
    chk("arst_valid", 32'(ifid_valid), 32'd0);
    chk("arst_instr", 32'(ifid_instr), 32'd0);
    chk("arst_pc", 32'(ifid_pc), 32'd0);
    chk("arst_count", 32'(fetch_count), 32'd0);
    chk("arst_addr", 32'(addr), 32'd0);
    @(posedge Clock);
    @(negedge Clock);
    #1;
    Resetn = 1'b1;
    tick(1'b0, 1'b0, 5'd0);
    chk("reboot_valid", 32'(ifid_valid), 32'd0);
    adv_expect(5'd0);
    chk("reboot_count", 32'(fetch_count), 32'd1);

    tick(1'b1, 1'b0, 5'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline, directly upstream of the unified 32x20 main memory's instruction read port.
- Owns the 5-bit PC and drives the memory instruction address.
- Captures the combinationally read 20-bit instruction into the IF/ID pipeline register.
- Handles stall from hazard logic, redirect from branch resolution, and an optional halt opcode.

Parameters:
- ADDR_W, 5, PC / memory address width
- INSTR_W, 20, instruction width
- RESET_PC, 0, PC value loaded on reset
- CNT_W, 8, width of fetched-instruction counter

Ports:
- Clock  in  1  system clock; all state updates on posedge
- Resetn  in  1  asynchronous active-low reset
- addr  out  ADDR_W  instruction address to memory; equals PC register
- q  in  INSTR_W  instruction read from memory at addr, same cycle, combinational
- stall  in  1  hold PC and IF/ID contents
- redirect  in  1  branch/jump taken; load redirect_pc
- redirect_pc  in  ADDR_W  redirect target
- ifid_instr  out  INSTR_W  registered instruction
- ifid_pc  out  ADDR_W  PC of ifid_instr
- ifid_valid  out  1  ifid_instr is a real instruction, not a bubble
- halted  out  1  fetch stopped on halt opcode; constant 0 when the macro is off
- fetch_count  out  CNT_W  instructions captured since reset, saturating

Behaviour:
- Reset (Resetn=0, async):
  - PC=RESET_PC, ifid_instr=0, ifid_pc=0, ifid_valid=0, halted=0, fetch_count=0.
  - State=S_BOOT.
- States:
  - S_BOOT: one cycle after reset release; no capture; ifid_valid stays 0; next state S_RUN. Redirect in S_BOOT still loads the PC; stall is ignored.
  - S_RUN: normal fetch.
  - S_HALT: only with the macro.
- Per-posedge priority in S_RUN: redirect > stall > advance.
- redirect=1:
  - PC<=redirect_pc.
  - ifid_valid<=0 (bubble), ifid_instr<=0.
  - fetch_count unchanged.
  - Applies even if stall=1 in the same cycle.
- stall=1, redirect=0: PC, ifid_instr, ifid_pc, ifid_valid, fetch_count all held.
- Advance:
  - ifid_instr<=q, ifid_pc<=PC, ifid_valid<=1.
  - PC<=PC+1 modulo 2^ADDR_W (31 wraps to 0; no special casing of data words).
  - fetch_count increments, saturating at all-ones.
- Latency: instruction at address A appears on ifid_instr one posedge after PC=A with no stall or redirect.
- Timing: memory writes occur on negedge. Fetch samples q at posedge and takes no part in write arbitration.
- Single always block for sequential state; next-PC mux is combinational.

Optional Feature:
- Macro FETCH_HALT_EN.
- With the macro:
  - On advance, if q[INSTR_W-1:INSTR_W-4]==OP_HALT (4'b1100), the halt instruction is still captured with ifid_valid=1.
  - PC then holds at the halt address and state goes to S_HALT, with halted=1.
  - In S_HALT every later cycle captures a bubble (ifid_valid=0) and stall is ignored.
  - Redirect leaves S_HALT: PC<=redirect_pc, halted<=0, state S_RUN.
- Without the macro: opcode 1100 is fetched like any other instruction; halted is tied 0; S_HALT does not exist.

Decomposition:
- Shared package pipe_pkg:
  - ADDR_W and INSTR_W defaults.
  - Opcode constants: OP_ADD=4'b0000, OP_HALT=4'b1100, OP_COPY_IN=4'b1111.
  - Fetch state encoding: S_BOOT, S_RUN, S_HALT.
  - Bubble value 0, which decodes as a no-op in downstream stages.
- Sub-module: pc_reg (PC register with load/hold/increment-wrap, async active-low reset). Everything else stays inline.

Test Plan:
- Reset, then run with memory 0..2 = copy instructions: cycle 1 ifid_valid=0 (boot); cycles 2..4 ifid_pc=0,1,2 with matching ifid_instr; fetch_count=3.
- stall=1 for 3 cycles while ifid_pc=1: ifid_pc, ifid_instr and addr frozen, fetch_count frozen; on release ifid_pc=2 next cycle.
- redirect=1 with redirect_pc=7, stall=1 in the same cycle: next cycle ifid_valid=0 and addr=7; following cycle ifid_instr=Mem[7] (add), ifid_pc=7.
- Redirect to 31 and run 2 cycles: ifid_pc=31 then 0 (wrap).
- Assert Resetn=0 mid-stream at ifid_pc=5: outputs go to reset values immediately without waiting for a clock; after release, boot bubble then ifid_pc=0.
- FETCH_HALT_EN, Mem[3]=1100_0000_0000_0000_0000: ifid_pc=3 valid, then halted=1 with bubbles and addr stuck at 3; redirect to 0 clears halted and resumes fetching. Without the macro, the same program gives ifid_pc=4 next.
